scheduler_divergent: RTL and testbench



---
 rtl/scheduler_divergent.sv | 176 +++++++++++++++++
 tb/tb_scheduler_divergent.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scheduler_divergent.sv
// Purpose: per-core warp scheduler with a private PC per thread and minimum-PC reconvergence on divergence.
// Latency: 6 cycles per non-memory instruction (FETCH..UPDATE); current_pc/active_mask are registered outputs.
// Backpressure: holds in FETCH until the fetcher reports FETCHED, and in WAIT while any active thread's LSU is busy.
module scheduler_divergent #(
    parameter int THREADS_PER_BLOCK = 4,
    parameter int PC_BITS           = 8,
    parameter int TC_BITS           = $clog2(THREADS_PER_BLOCK + 1)
) (
    input  logic                                 i_clk,
    input  logic                                 i_reset,
    input  logic                                 i_start,
    input  logic [TC_BITS-1:0]                   i_thread_count,
    input  logic [2:0]                           i_fetcher_state,
    input  logic                                 i_decoded_ret,
    input  logic [2*THREADS_PER_BLOCK-1:0]       i_lsu_state,
    input  logic [PC_BITS*THREADS_PER_BLOCK-1:0] i_next_pc,
    output logic [PC_BITS-1:0]                   o_current_pc,
    output logic [THREADS_PER_BLOCK-1:0]         o_active_mask,
    output logic [2:0]                           o_core_state,
    output logic                                 o_done
);

    localparam logic [2:0] S_IDLE    = 3'b000;
    localparam logic [2:0] S_FETCH   = 3'b001;
    localparam logic [2:0] S_DECODE  = 3'b010;
    localparam logic [2:0] S_REQUEST = 3'b011;
    localparam logic [2:0] S_WAIT    = 3'b100;
    localparam logic [2:0] S_EXECUTE = 3'b101;
    localparam logic [2:0] S_UPDATE  = 3'b110;
    localparam logic [2:0] S_DONE    = 3'b111;

    localparam logic [2:0] FETCHED    = 3'b010;
    localparam logic [1:0] LSU_REQ    = 2'b01;
    localparam logic [1:0] LSU_WAIT   = 2'b10;

    logic [2:0]                   r_state;
    logic [2:0]                   w_state_nxt;
    logic [PC_BITS-1:0]           r_pc [THREADS_PER_BLOCK];
    logic [THREADS_PER_BLOCK-1:0] r_live;
    logic [PC_BITS-1:0]           r_current_pc;
    logic [THREADS_PER_BLOCK-1:0] r_active_mask;

    logic [THREADS_PER_BLOCK-1:0] w_start_live;
    logic                         w_lsu_busy;
    logic [PC_BITS-1:0]           w_pc_upd [THREADS_PER_BLOCK];
    logic [THREADS_PER_BLOCK-1:0] w_live_upd;
    logic [PC_BITS-1:0]           w_min_pc;
    logic [THREADS_PER_BLOCK-1:0] w_min_mask;
    logic                         w_any_live;

    // Threads enabled on start; indices beyond the block size never exist, so the compare saturates naturally.
    always_comb begin
        w_start_live = '0;
        for (int i = 0; i < THREADS_PER_BLOCK; i++) begin
            w_start_live[i] = (TC_BITS'(i) < i_thread_count);
        end
    end

    // Memory stall: only LSUs of threads issuing the current instruction can hold WAIT.
    always_comb begin
        w_lsu_busy = 1'b0;
        for (int i = 0; i < THREADS_PER_BLOCK; i++) begin
            if (r_active_mask[i] && (i_lsu_state[2*i +: 2] == LSU_REQ ||
                                     i_lsu_state[2*i +: 2] == LSU_WAIT)) begin
                w_lsu_busy = 1'b1;
            end
        end
    end

    // Post-UPDATE thread state: active threads retire on RET or take their computed next PC.
    always_comb begin
        w_live_upd = r_live;
        for (int i = 0; i < THREADS_PER_BLOCK; i++) begin
            w_pc_upd[i] = r_pc[i];
            if (r_active_mask[i]) begin
                if (i_decoded_ret) begin
                    w_live_upd[i] = 1'b0;
                end else begin
                    w_pc_upd[i] = i_next_pc[PC_BITS*i +: PC_BITS];
                end
            end
        end
    end

    // Reconvergence: the next issue group is every live thread sitting at the smallest live PC.
    always_comb begin
        w_min_pc   = '1;
        w_min_mask = '0;
        w_any_live = |w_live_upd;
        for (int i = 0; i < THREADS_PER_BLOCK; i++) begin
            if (w_live_upd[i] && (w_pc_upd[i] < w_min_pc)) begin
                w_min_pc = w_pc_upd[i];
            end
        end
        for (int i = 0; i < THREADS_PER_BLOCK; i++) begin
            w_min_mask[i] = w_live_upd[i] && (w_pc_upd[i] == w_min_pc);
        end
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic for the instruction cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt = (i_thread_count == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                if (i_fetcher_state == FETCHED) begin
                    w_state_nxt = S_DECODE;
                end
            end
            S_DECODE:  w_state_nxt = S_REQUEST;
            S_REQUEST: w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (!w_lsu_busy) begin
                    w_state_nxt = S_EXECUTE;
                end
            end
            S_EXECUTE: w_state_nxt = S_UPDATE;
            S_UPDATE:  w_state_nxt = w_any_live ? S_FETCH : S_DONE;
            default:   w_state_nxt = S_DONE;
        endcase
    end

    // Outputs decoded from state; done is simply "in DONE" so it rises with the state change.
    always_comb begin
        o_core_state  = r_state;
        o_done        = (r_state == S_DONE);
        o_current_pc  = r_current_pc;
        o_active_mask = r_active_mask;
    end

    // Per-thread PCs, live set and the issue PC/mask; these only move on IDLE exit and at the end of UPDATE.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int i = 0; i < THREADS_PER_BLOCK; i++) begin
                r_pc[i] <= '0;
            end
            r_live        <= '0;
            r_current_pc  <= '0;
            r_active_mask <= '0;
        end else begin
            if (r_state == S_IDLE && i_start && i_thread_count != '0) begin
                for (int i = 0; i < THREADS_PER_BLOCK; i++) begin
                    r_pc[i] <= '0;
                end
                r_live        <= w_start_live;
                r_current_pc  <= '0;
                r_active_mask <= w_start_live;
            end else if (r_state == S_UPDATE) begin
                for (int i = 0; i < THREADS_PER_BLOCK; i++) begin
                    r_pc[i] <= w_pc_upd[i];
                end
                r_live <= w_live_upd;
                if (w_any_live) begin
                    r_current_pc  <= w_min_pc;
                    r_active_mask <= w_min_mask;
                end else begin
                    r_active_mask <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_scheduler_divergent.sv
// Purpose: randomized self-checking bench for scheduler_divergent against a per-thread PC/live reference model.
// Latency: inputs driven 1 time unit after posedge, outputs sampled at the same point, one edge later.
// Backpressure: fetch delays and LSU busy periods are injected to exercise the FETCH and WAIT holds.
module tb_scheduler_divergent;

    localparam int T = 4;
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FETCH   = 3'd1;
    localparam logic [2:0] S_DECODE  = 3'd2;
    localparam logic [2:0] S_REQUEST = 3'd3;
    localparam logic [2:0] S_WAIT    = 3'd4;
    localparam logic [2:0] S_EXECUTE = 3'd5;
    localparam logic [2:0] S_UPDATE  = 3'd6;
    localparam logic [2:0] S_DONE    = 3'd7;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  tc;
    logic [2:0]  fs;
    logic        ret;
    logic [7:0]  lsu;
    logic [31:0] npc;
    logic [7:0]  cur;
    logic [3:0]  mask;
    logic [2:0]  st;
    logic        done;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Program: per-thread branch target for each PC, and whether the instruction at a PC is RET.
    int tgt [T][256];
    bit retp [256];
    // Reference model state.
    int mpc [T];
    bit mlive [T];
    // Issue log: (pc, mask) for every instruction issued in the current run.
    int         iss_pc [$];
    logic [3:0] iss_mask [$];

    scheduler_divergent dut (
        .i_clk           (clk),
        .i_reset         (rst_n),
        .i_start         (start),
        .i_thread_count  (tc),
        .i_fetcher_state (fs),
        .i_decoded_ret   (ret),
        .i_lsu_state     (lsu),
        .i_next_pc       (npc),
        .o_current_pc    (cur),
        .o_active_mask   (mask),
        .o_core_state    (st),
        .o_done          (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue group from the model: all live threads at the lowest live PC.
    function automatic logic [3:0] model_mask(output int m);
        logic [3:0] r;
        bit any;
        r = '0;
        any = 1'b0;
        m = 0;
        for (int t = 0; t < T; t++) begin
            if (mlive[t] && (!any || mpc[t] < m)) begin
                m = mpc[t];
                any = 1'b1;
            end
        end
        for (int t = 0; t < T; t++) r[t] = mlive[t] && (mpc[t] == m);
        return r;
    endfunction

    function automatic logic [2:0] not_fetched();
        int v;
        v = $urandom_range(0, 6);
        if (v >= 2) v++;
        return 3'(v);
    endfunction

    function automatic logic [7:0] lsu_pat(input logic [3:0] am, input bit busy);
        logic [7:0] r;
        for (int t = 0; t < T; t++) begin
            if (am[t]) r[2*t +: 2] = busy ? ($urandom_range(0, 1) ? 2'b01 : 2'b10)
                                          : ($urandom_range(0, 1) ? 2'b00 : 2'b11);
            else       r[2*t +: 2] = 2'($urandom);
        end
        return r;
    endfunction

    task automatic clear_prog;
        for (int t = 0; t < T; t++)
            for (int p = 0; p < 256; p++) tgt[t][p] = p + 1;
        for (int p = 0; p < 256; p++) retp[p] = 1'b0;
    endtask

    task automatic do_reset;
        start = 1'b0; tc = '0; fs = '0; ret = 1'b0; lsu = '0; npc = '0;
        rst_n = 1'b0;
        repeat (2) tick;
        rst_n = 1'b1;
        tick;
    endtask

    // One instruction from FETCH entry through the UPDATE edge, checking every cycle.
    task automatic run_instr(input int fdly, input int w, output bit fin);
        int m, m2, wc;
        logic [3:0] em, em2;
        logic [2:0] seq [$];
        logic [2:0] pre;
        em = model_mask(m);
        iss_pc.push_back(m);
        iss_mask.push_back(em);
        n_cmp++;
        if ({st, cur, mask, done} !== {S_FETCH, 8'(m), em, 1'b0}) begin
            n_err++;
            $display("FAIL issue: got st=%0d pc=%0d mask=%b done=%b, want st=1 pc=%0d mask=%b done=0",
                     st, cur, mask, done, m, em);
        end
        seq = {};
        repeat (fdly) seq.push_back(S_FETCH);
        seq.push_back(S_DECODE);
        seq.push_back(S_REQUEST);
        seq.push_back(S_WAIT);
        repeat (w) seq.push_back(S_WAIT);
        seq.push_back(S_EXECUTE);
        seq.push_back(S_UPDATE);
        pre = S_FETCH;
        wc = 0;
        for (int k = 0; k < seq.size(); k++) begin
            fs  = not_fetched();
            lsu = 8'($urandom);
            ret = 1'($urandom);
            npc = $urandom;
            if (pre == S_FETCH && seq[k] != S_FETCH) fs = 3'b010;
            if (pre == S_WAIT) lsu = lsu_pat(em, seq[k] == S_WAIT);
            tick;
            n_cmp++;
            if ({st, cur, mask, done} !== {seq[k], 8'(m), em, 1'b0}) begin
                n_err++;
                $display("FAIL step%0d: got st=%0d pc=%0d mask=%b done=%b, want st=%0d pc=%0d mask=%b done=0",
                         k, st, cur, mask, done, seq[k], m, em);
            end
            pre = seq[k];
        end
        ret = retp[m];
        for (int t = 0; t < T; t++) npc[8*t +: 8] = em[t] ? 8'(tgt[t][mpc[t]]) : 8'($urandom);
        lsu = 8'($urandom);
        tick;
        for (int t = 0; t < T; t++) begin
            if (em[t]) begin
                if (retp[m]) mlive[t] = 1'b0;
                else         mpc[t] = tgt[t][mpc[t]];
            end
        end
        em2 = model_mask(m2);
        fin = (em2 == '0);
        n_cmp++;
        if (fin) begin
            if ({st, cur, mask, done} !== {S_DONE, 8'(m), 4'b0000, 1'b1}) begin
                n_err++;
                $display("FAIL retire: got st=%0d pc=%0d mask=%b done=%b, want st=7 pc=%0d mask=0000 done=1",
                         st, cur, mask, done, m);
            end
        end else if ({st, cur, mask, done} !== {S_FETCH, 8'(m2), em2, 1'b0}) begin
            n_err++;
            $display("FAIL update: got st=%0d pc=%0d mask=%b done=%b, want st=1 pc=%0d mask=%b done=0",
                     st, cur, mask, done, m2, em2);
        end
        ret = 1'($urandom);
    endtask

    // Full program run from IDLE with start held high throughout.
    task automatic run_program(input int tcv, input int fmin, input int fmax,
                               input int wmin, input int wmax, output int cycles);
        int n, c0, lastpc;
        bit fin;
        iss_pc = {};
        iss_mask = {};
        n = (tcv > T) ? T : tcv;
        for (int t = 0; t < T; t++) begin
            mlive[t] = (t < n);
            mpc[t] = 0;
        end
        start = 1'b1;
        tc = 3'(tcv);
        tick;
        c0 = cyc;
        fin = (n == 0);
        if (n == 0) begin
            n_cmp++;
            if ({st, cur, mask, done} !== {S_DONE, 8'd0, 4'b0000, 1'b1}) begin
                n_err++;
                $display("FAIL zero_threads: got st=%0d pc=%0d mask=%b done=%b, want st=7 pc=0 mask=0000 done=1",
                         st, cur, mask, done);
            end
        end
        for (int i = 0; i < 200 && !fin; i++)
            run_instr($urandom_range(fmin, fmax), $urandom_range(wmin, wmax), fin);
        cycles = cyc - c0;
        if (!fin) begin
            n_cmp++;
            n_err++;
            $display("FAIL timeout: program still running after 200 instructions, want DONE");
        end
        lastpc = (iss_pc.size() > 0) ? iss_pc[$] : 0;
        repeat (3) tick;
        n_cmp++;
        if ({st, cur, mask, done} !== {S_DONE, 8'(lastpc), 4'b0000, 1'b1}) begin
            n_err++;
            $display("FAIL done_hold: got st=%0d pc=%0d mask=%b done=%b, want st=7 pc=%0d mask=0000 done=1",
                     st, cur, mask, done, lastpc);
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; tc = '0; fs = '0; ret = 1'b0; lsu = '0; npc = '0;
        #2;
        n_cmp++;
        if ({st, cur, mask, done} !== {S_IDLE, 8'd0, 4'b0000, 1'b0}) begin
            n_err++;
            $display("FAIL reset: got st=%0d pc=%0d mask=%b done=%b, want all zero", st, cur, mask, done);
        end
        tick;
        rst_n = 1'b1;
        tc = 3'd4;
        repeat (3) tick;
        n_cmp++;
        if ({st, done} !== {S_IDLE, 1'b0}) begin
            n_err++;
            $display("FAIL idle_hold: got st=%0d done=%b, want st=0 done=0", st, done);
        end
    endtask

    task automatic test_uniform;
        int cy;
        do_reset;
        clear_prog;
        retp[3] = 1'b1;
        run_program(4, 0, 0, 0, 0, cy);
        n_cmp++;
        if (cy !== 24) begin
            n_err++;
            $display("FAIL uniform_cycles: got %0d, want 24", cy);
        end
        n_cmp++;
        if (iss_pc.size() !== 4) begin
            n_err++;
            $display("FAIL uniform_count: got %0d issues, want 4", iss_pc.size());
        end
        for (int i = 0; i < iss_pc.size() && i < 4; i++) begin
            n_cmp++;
            if (iss_pc[i] !== i || iss_mask[i] !== 4'b1111) begin
                n_err++;
                $display("FAIL uniform_issue%0d: got pc=%0d mask=%b, want pc=%0d mask=1111",
                         i, iss_pc[i], iss_mask[i], i);
            end
        end
    endtask

    task automatic test_divergence;
        int cy;
        int         xp [6] = '{0, 1, 2, 3, 4, 5};
        logic [3:0] xm [6] = '{4'b1111, 4'b1111, 4'b1111, 4'b1100, 4'b1100, 4'b1111};
        do_reset;
        clear_prog;
        tgt[0][2] = 5;
        tgt[1][2] = 5;
        retp[5] = 1'b1;
        run_program(4, 0, 1, 0, 1, cy);
        n_cmp++;
        if (iss_pc.size() !== 6) begin
            n_err++;
            $display("FAIL diverge_count: got %0d issues, want 6", iss_pc.size());
        end
        for (int i = 0; i < iss_pc.size() && i < 6; i++) begin
            n_cmp++;
            if (iss_pc[i] !== xp[i] || iss_mask[i] !== xm[i]) begin
                n_err++;
                $display("FAIL diverge_issue%0d: got pc=%0d mask=%b, want pc=%0d mask=%b",
                         i, iss_pc[i], iss_mask[i], xp[i], xm[i]);
            end
        end
    endtask

    task automatic test_partial_retire;
        int cy;
        int         xp [4] = '{0, 1, 2, 4};
        logic [3:0] xm [4] = '{4'b1111, 4'b1111, 4'b0011, 4'b1100};
        do_reset;
        clear_prog;
        tgt[2][1] = 4;
        tgt[3][1] = 4;
        retp[2] = 1'b1;
        retp[4] = 1'b1;
        run_program(4, 0, 1, 0, 1, cy);
        n_cmp++;
        if (iss_pc.size() !== 4) begin
            n_err++;
            $display("FAIL retire_count: got %0d issues, want 4", iss_pc.size());
        end
        for (int i = 0; i < iss_pc.size() && i < 4; i++) begin
            n_cmp++;
            if (iss_pc[i] !== xp[i] || iss_mask[i] !== xm[i]) begin
                n_err++;
                $display("FAIL retire_issue%0d: got pc=%0d mask=%b, want pc=%0d mask=%b",
                         i, iss_pc[i], iss_mask[i], xp[i], xm[i]);
            end
        end
    endtask

    // Two live threads with a 5-cycle WAIT; LSU fields of inactive threads 2 and 3 carry random busy codes.
    task automatic test_lsu_gating;
        int cy;
        do_reset;
        clear_prog;
        retp[1] = 1'b1;
        run_program(2, 0, 0, 4, 4, cy);
        n_cmp++;
        if (cy !== 2 * 10) begin
            n_err++;
            $display("FAIL lsu_cycles: got %0d, want 20", cy);
        end
    endtask

    task automatic test_edge_counts;
        int cy;
        do_reset;
        clear_prog;
        run_program(0, 0, 0, 0, 0, cy);
        do_reset;
        retp[1] = 1'b1;
        run_program(1, 0, 2, 0, 2, cy);
        n_cmp++;
        if (iss_mask.size() < 1 || iss_mask[0] !== 4'b0001) begin
            n_err++;
            $display("FAIL one_thread: got mask=%b, want 0001", (iss_mask.size() > 0) ? iss_mask[0] : 4'bx);
        end
        do_reset;
        run_program(7, 0, 0, 0, 0, cy);
        n_cmp++;
        if (iss_mask.size() < 1 || iss_mask[0] !== 4'b1111) begin
            n_err++;
            $display("FAIL saturate: got mask=%b, want 1111", (iss_mask.size() > 0) ? iss_mask[0] : 4'bx);
        end
    endtask

    task automatic test_async_reset;
        int cy;
        bit fin;
        do_reset;
        clear_prog;
        tgt[2][0] = 3;
        tgt[3][0] = 3;
        retp[4] = 1'b1;
        for (int t = 0; t < T; t++) begin
            mlive[t] = 1'b1;
            mpc[t] = 0;
        end
        start = 1'b1;
        tc = 3'd4;
        tick;
        start = 1'b0;
        run_instr(0, 0, fin);
        fs = 3'b010;
        tick;
        fs = 3'b000;
        repeat (2) tick;
        lsu = 8'h00;
        tick;
        n_cmp++;
        if ({st, cur, mask} !== {S_EXECUTE, 8'd1, 4'b0011}) begin
            n_err++;
            $display("FAIL pre_reset: got st=%0d pc=%0d mask=%b, want st=5 pc=1 mask=0011", st, cur, mask);
        end
        #3 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({st, cur, mask, done} !== {S_IDLE, 8'd0, 4'b0000, 1'b0}) begin
            n_err++;
            $display("FAIL async_reset: got st=%0d pc=%0d mask=%b done=%b, want all zero",
                     st, cur, mask, done);
        end
        tick;
        rst_n = 1'b1;
        tick;
        clear_prog;
        retp[3] = 1'b1;
        run_program(4, 0, 2, 0, 2, cy);
        n_cmp++;
        if (iss_pc.size() !== 4) begin
            n_err++;
            $display("FAIL rerun: got %0d issues, want 4", iss_pc.size());
        end
    endtask

    task automatic test_random;
        int cy;
        for (int r = 0; r < 20; r++) begin
            do_reset;
            for (int p = 0; p < 256; p++) begin
                for (int t = 0; t < T; t++) tgt[t][p] = p + $urandom_range(1, 3);
                retp[p] = (p >= 30) || ($urandom_range(0, 7) == 0);
            end
            retp[0] = 1'b0;
            run_program($urandom_range(1, 7), 0, 2, 0, 3, cy);
        end
    endtask

    initial begin
        test_reset;
        test_uniform;
        test_divergence;
        test_partial_retire;
        test_lsu_gating;
        test_edge_counts;
        test_async_reset;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
